// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and defaults for the data-memory arbiter and its byte-lane aligner.
package dmem_arbiter_pkg;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RESP = 1'b1
    } state_e;

    localparam int unsigned MEM_ADDR_WIDTH_DEFAULT = 10;
    localparam int unsigned MEM_DEPTH_DEFAULT      = 256;

    // Sign- or zero-extend an 8- or 16-bit load value held in the low bits of v.
    function automatic logic [31:0] extend_load(input logic [31:0] v, input logic is_half,
                                                input logic zero_ext);
        logic [31:0] r;
        if (is_half) begin
            r = zero_ext ? {16'h0000, v[15:0]} : {{16{v[15]}}, v[15:0]};
        end else begin
            r = zero_ext ? {24'h000000, v[7:0]} : {{24{v[7]}}, v[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_arbiter_lane_align.sv
// Combinational byte-lane aligner: write mask, lane-replicated store data, extended load data.
module dmem_lane_align
    import dmem_arbiter_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        load_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  mask,
    output logic [31:0] wdata_lane,
    output logic [31:0] rdata_ext,
    output logic        misalign
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    assign lane_byte = rdata[{addr_lo, 3'b000} +: 8];
    assign lane_half = rdata[{addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        mask       = 4'b0000;
        wdata_lane = '0;
        rdata_ext  = '0;
        misalign   = 1'b0;
        case (size)
            SZ_BYTE: begin
                mask       = 4'b0001 << addr_lo;
                wdata_lane = {4{wdata[7:0]}};
                rdata_ext  = extend_load({24'h000000, lane_byte}, 1'b0, load_unsigned);
            end
            SZ_HALF: begin
                mask       = 4'b0011 << {addr_lo[1], 1'b0};
                wdata_lane = {2{wdata[15:0]}};
                rdata_ext  = extend_load({16'h0000, lane_half}, 1'b1, load_unsigned);
                misalign   = addr_lo[0];
            end
            SZ_WORD: begin
                mask       = 4'b1111;
                wdata_lane = wdata;
                rdata_ext  = rdata;
                misalign   = |addr_lo;
            end
            default: begin
                // Illegal size is reported through the same error path as misalignment.
                misalign = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter and byte-lane controller for the single-port data memory.
// Define DMEM_ARB_ROUND_ROBIN_EN for round-robin conflict resolution; default is port 0 priority.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = MEM_ADDR_WIDTH_DEFAULT,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TRANSFER_WIDTH = 4,
    parameter int unsigned MEM_DEPTH      = MEM_DEPTH_DEFAULT
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic                      p0_req,
    output logic                      p0_gnt,
    input  logic                      p0_we,
    input  logic [ADDR_WIDTH-1:0]     p0_addr,
    input  logic [DATA_WIDTH-1:0]     p0_wdata,
    input  logic [1:0]                p0_size,
    input  logic                      p0_unsigned,
    output logic                      p0_rsp_valid,
    output logic [DATA_WIDTH-1:0]     p0_rsp_rdata,
    output logic                      p0_rsp_err,
    input  logic                      p0_rsp_ready,

    input  logic                      p1_req,
    output logic                      p1_gnt,
    input  logic                      p1_we,
    input  logic [ADDR_WIDTH-1:0]     p1_addr,
    input  logic [DATA_WIDTH-1:0]     p1_wdata,
    input  logic [1:0]                p1_size,
    input  logic                      p1_unsigned,
    output logic                      p1_rsp_valid,
    output logic [DATA_WIDTH-1:0]     p1_rsp_rdata,
    output logic                      p1_rsp_err,
    input  logic                      p1_rsp_ready,

    output logic                      mem_we,
    output logic [ADDR_WIDTH-1:0]     mem_addr,
    output logic [DATA_WIDTH-1:0]     mem_wdata,
    output logic [TRANSFER_WIDTH-1:0] mem_wtransfer,
    input  logic [DATA_WIDTH-1:0]     mem_rdata
);

    state_e                state_q, state_d;
    logic                  owner_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  err_q;

    logic                  gnt_any;
    logic                  win;
    logic                  owner_ready;

    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [1:0]            sel_size;
    logic                  sel_unsigned;

    logic [ADDR_WIDTH-1:0] word_idx;
    logic                  out_of_range;
    logic                  misalign;
    logic                  acc_err;
    logic [3:0]            lane_mask;
    logic [31:0]           lane_wdata;
    logic [31:0]           lane_rdata;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
    logic                  last_grant_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else if (gnt_any) begin
            last_grant_q <= win;
        end
    end
`endif

    // Arbitration: only in IDLE, winner granted combinationally in the same cycle.
    always_comb begin
        gnt_any = 1'b0;
        win     = 1'b0;
        if (state_q == ST_IDLE) begin
            if (p0_req && p1_req) begin
                gnt_any = 1'b1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                win     = ~last_grant_q;
`else
                win     = 1'b0;
`endif
            end else if (p0_req) begin
                gnt_any = 1'b1;
                win     = 1'b0;
            end else if (p1_req) begin
                gnt_any = 1'b1;
                win     = 1'b1;
            end
        end
    end

    assign p0_gnt = gnt_any & ~win;
    assign p1_gnt = gnt_any & win;

    assign sel_we       = win ? p1_we       : p0_we;
    assign sel_addr     = win ? p1_addr     : p0_addr;
    assign sel_wdata    = win ? p1_wdata    : p0_wdata;
    assign sel_size     = win ? p1_size     : p0_size;
    assign sel_unsigned = win ? p1_unsigned : p0_unsigned;

    dmem_lane_align u_lane_align (
        .size          (sel_size),
        .addr_lo       (sel_addr[1:0]),
        .load_unsigned (sel_unsigned),
        .wdata         (sel_wdata[31:0]),
        .rdata         (mem_rdata[31:0]),
        .mask          (lane_mask),
        .wdata_lane    (lane_wdata),
        .rdata_ext     (lane_rdata),
        .misalign      (misalign)
    );

    assign word_idx     = sel_addr >> 2;
    assign out_of_range = (32'(word_idx) >= MEM_DEPTH);
    assign acc_err      = misalign | out_of_range;

    // Memory is only driven during the grant cycle; errored accesses never write.
    always_comb begin
        mem_we        = 1'b0;
        mem_addr      = '0;
        mem_wdata     = '0;
        mem_wtransfer = '0;
        if (gnt_any) begin
            mem_addr = sel_addr;
            if (sel_we && !acc_err) begin
                mem_we        = 1'b1;
                mem_wdata     = DATA_WIDTH'(lane_wdata);
                mem_wtransfer = TRANSFER_WIDTH'(lane_mask);
            end
        end
    end

    assign owner_ready = owner_q ? p1_rsp_ready : p0_rsp_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (owner_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            owner_q <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (gnt_any) begin
                owner_q <= win;
                err_q   <= acc_err;
                rdata_q <= (acc_err || sel_we) ? '0 : DATA_WIDTH'(lane_rdata);
            end
        end
    end

    assign p0_rsp_valid = (state_q == ST_RESP) && !owner_q;
    assign p1_rsp_valid = (state_q == ST_RESP) && owner_q;
    assign p0_rsp_rdata = p0_rsp_valid ? rdata_q : '0;
    assign p1_rsp_rdata = p1_rsp_valid ? rdata_q : '0;
    assign p0_rsp_err   = p0_rsp_valid & err_q;
    assign p1_rsp_err   = p1_rsp_valid & err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed cases plus randomized two-port traffic
// checked every cycle against a byte-addressed transaction-level model.
module tb_dmem_arbiter;

    localparam int unsigned AW    = 11;
    localparam int unsigned DEPTH = 256;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic          req   [2];
    logic          we    [2];
    logic          uns   [2];
    logic          ready [2];
    logic [AW-1:0] addr  [2];
    logic [31:0]   wdata [2];
    logic [1:0]    size  [2];
    logic          gnt       [2];
    logic          rsp_valid [2];
    logic          rsp_err   [2];
    logic [31:0]   rsp_rdata [2];

    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata;
    logic [3:0]    mem_wtransfer;

    int n_checks = 0;
    int n_fails  = 0;

    dmem_arbiter #(
        .ADDR_WIDTH     (AW),
        .DATA_WIDTH     (32),
        .TRANSFER_WIDTH (4),
        .MEM_DEPTH      (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .p0_req        (req[0]),
        .p0_gnt        (gnt[0]),
        .p0_we         (we[0]),
        .p0_addr       (addr[0]),
        .p0_wdata      (wdata[0]),
        .p0_size       (size[0]),
        .p0_unsigned   (uns[0]),
        .p0_rsp_valid  (rsp_valid[0]),
        .p0_rsp_rdata  (rsp_rdata[0]),
        .p0_rsp_err    (rsp_err[0]),
        .p0_rsp_ready  (ready[0]),
        .p1_req        (req[1]),
        .p1_gnt        (gnt[1]),
        .p1_we         (we[1]),
        .p1_addr       (addr[1]),
        .p1_wdata      (wdata[1]),
        .p1_size       (size[1]),
        .p1_unsigned   (uns[1]),
        .p1_rsp_valid  (rsp_valid[1]),
        .p1_rsp_rdata  (rsp_rdata[1]),
        .p1_rsp_err    (rsp_err[1]),
        .p1_rsp_ready  (ready[1]),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_wtransfer (mem_wtransfer),
        .mem_rdata     (mem_rdata)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        return 32'h9E3779B9 * 32'(i + 1);
    endfunction

    // Physical memory behind the arbiter.
    logic [31:0] env_mem [DEPTH];
    logic        clear_mem;

    always @(posedge clk) begin
        if (clear_mem) begin
            for (int i = 0; i < int'(DEPTH); i++) env_mem[i] <= init_word(i);
        end else if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wtransfer[b]) env_mem[mem_addr[9:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    assign mem_rdata = env_mem[mem_addr[9:2]];

    // ---------------- reference model (byte-addressed, transaction level) ----------------
    logic [7:0] ref_mem [1024];

    function automatic logic acc_err(input logic [1:0] sz, input logic [AW-1:0] a);
        int ai;
        ai = int'(a);
        return (sz == 2'b11) || (sz == 2'b01 && ai % 2 != 0) || (sz == 2'b10 && ai % 4 != 0)
            || (ai / 4 >= int'(DEPTH));
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] sz, input logic [AW-1:0] a);
        int ai;
        ai = int'(a) % 4;
        if (sz == 2'b00) return 4'(1 << ai);
        if (sz == 2'b01) return 4'(3 << ai);
        return 4'hF;
    endfunction

    function automatic logic [31:0] rep_data(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'b00) return {d[7:0], d[7:0], d[7:0], d[7:0]};
        if (sz == 2'b01) return {d[15:0], d[15:0]};
        return d;
    endfunction

    function automatic logic [31:0] load_val(input logic [1:0] sz, input logic [AW-1:0] a,
                                             input logic u);
        int          ai;
        logic [7:0]  b;
        logic [15:0] h;
        ai = int'(a);
        if (sz == 2'b00) begin
            b = ref_mem[ai];
            return u ? {24'h0, b} : {{24{b[7]}}, b};
        end
        if (sz == 2'b01) begin
            h = {ref_mem[ai+1], ref_mem[ai]};
            return u ? {16'h0, h} : {{16{h[15]}}, h};
        end
        return {ref_mem[ai+3], ref_mem[ai+2], ref_mem[ai+1], ref_mem[ai]};
    endfunction

    task automatic store_ref(input logic [1:0] sz, input logic [AW-1:0] a, input logic [31:0] d);
        int ai;
        ai = int'(a);
        ref_mem[ai] = d[7:0];
        if (sz != 2'b00) ref_mem[ai+1] = d[15:8];
        if (sz == 2'b10) begin
            ref_mem[ai+2] = d[23:16];
            ref_mem[ai+3] = d[31:24];
        end
    endtask

    logic        m_on = 1'b0;
    logic        m_busy = 1'b0;
    int          m_owner = 0;
    logic [31:0] m_rdata = '0;
    logic        m_err = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    int          m_last = 1;
`endif
    int          w;
    logic        have, e_err, st_ok;
    logic [3:0]  e_mask;
    logic [31:0] e_wdata, mtmp;
    logic [AW-1:0] e_addr;

    initial begin
        forever begin
            @(negedge clk);
            if (clear_mem) begin
                for (int i = 0; i < 1024; i++) begin
                    mtmp = init_word(i / 4);
                    ref_mem[i] = mtmp[8*(i%4) +: 8];
                end
            end
            have = 1'b0;
            w = 0;
            if (!m_busy) begin
                if (req[0] && req[1]) begin
                    have = 1'b1;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                    w = 1 - m_last;
`else
                    w = 0;
`endif
                end else if (req[0]) begin
                    have = 1'b1;
                    w = 0;
                end else if (req[1]) begin
                    have = 1'b1;
                    w = 1;
                end
            end
            e_err   = have ? acc_err(size[w], addr[w]) : 1'b0;
            st_ok   = have && we[w] && !e_err;
            e_mask  = st_ok ? lane_mask(size[w], addr[w]) : 4'h0;
            e_wdata = st_ok ? rep_data(size[w], wdata[w]) : 32'h0;
            e_addr  = have ? addr[w] : '0;
            if (m_on) begin
                check1("m_gnt0", gnt[0], have && w == 0);
                check1("m_gnt1", gnt[1], have && w == 1);
                check1("m_mem_we", mem_we, st_ok);
                check32("m_mem_wtransfer", {28'h0, mem_wtransfer}, {28'h0, e_mask});
                check32("m_mem_wdata", mem_wdata, e_wdata);
                check32("m_mem_addr", 32'(mem_addr), 32'(e_addr));
                for (int n = 0; n < 2; n++) begin
                    check1("m_rsp_valid", rsp_valid[n], m_busy && m_owner == n);
                    check32("m_rsp_rdata", rsp_rdata[n],
                            (m_busy && m_owner == n) ? m_rdata : 32'h0);
                    check1("m_rsp_err", rsp_err[n], m_busy && m_owner == n && m_err);
                end
            end
            if (rst) begin
                m_on   = 1'b1;
                m_busy = 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                m_last = 1;
`endif
            end else if (have) begin
                m_rdata = (!we[w] && !e_err) ? load_val(size[w], addr[w], uns[w]) : 32'h0;
                if (st_ok) store_ref(size[w], addr[w], wdata[w]);
                m_busy  = 1'b1;
                m_owner = w;
                m_err   = e_err;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                m_last  = w;
`endif
            end else if (m_busy && ready[m_owner]) begin
                m_busy = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_gnt(input int n, output logic got);
        got = 1'b0;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            got = gnt[n];
        end
        if (!got) check1("gnt_timeout", gnt[n], 1'b1);
    endtask

    task automatic access(input int n, input logic w_i, input logic [AW-1:0] a,
                          input logic [31:0] d, input logic [1:0] s, input logic u,
                          input logic [3:0] x_mask, input logic [31:0] x_rdata,
                          input logic x_err);
        logic got;
        we[n] = w_i; addr[n] = a; wdata[n] = d; size[n] = s; uns[n] = u; req[n] = 1'b1;
        wait_gnt(n, got);
        if (got) begin
            check32("d_mask", {28'h0, mem_wtransfer}, {28'h0, x_mask});
            check1("d_mem_we", mem_we, w_i && !x_err);
        end
        @(posedge clk); #1;
        req[n] = 1'b0;
        @(negedge clk);
        check1("d_rsp_valid", rsp_valid[n], 1'b1);
        check32("d_rdata", rsp_rdata[n], x_rdata);
        check1("d_err", rsp_err[n], x_err);
        @(posedge clk); #1;
    endtask

    task automatic new_txn(input int n);
        int unsigned r, base;
        we[n] = 1'($urandom_range(0, 1));
        r = $urandom_range(0, 9);
        size[n] = (r == 9) ? 2'b11 : 2'(r % 3);
        r = $urandom_range(0, 9);
        if (r == 0)      base = $urandom_range(1024, 2047);
        else if (r < 7)  base = $urandom_range(0, 63);
        else             base = $urandom_range(0, 1023);
        if ($urandom_range(0, 9) < 7) begin
            if (size[n] == 2'b01) base = base & ~32'd1;
            if (size[n] == 2'b10) base = base & ~32'd3;
        end
        addr[n]  = AW'(base);
        wdata[n] = $urandom;
        uns[n]   = 1'($urandom_range(0, 1));
        req[n]   = 1'b1;
    endtask

    int   seq [$];
    logic gs [2];
    logic got_g;

    initial begin
        rst = 1'b1;
        clear_mem = 1'b1;
        for (int n = 0; n < 2; n++) begin
            req[n] = 1'b0; we[n] = 1'b0; uns[n] = 1'b0; ready[n] = 1'b1;
            addr[n] = '0; wdata[n] = '0; size[n] = 2'b00;
        end
        @(posedge clk); @(posedge clk);
        @(negedge clk);
        check1("rst_gnt0", gnt[0], 1'b0);
        check1("rst_valid0", rsp_valid[0], 1'b0);
        check1("rst_valid1", rsp_valid[1], 1'b0);
        check1("rst_mem_we", mem_we, 1'b0);
        check32("rst_wtransfer", {28'h0, mem_wtransfer}, 32'h0);
        check32("rst_rdata0", rsp_rdata[0], 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        clear_mem = 1'b0;

        // Word, byte and half stores/loads with literal expectations.
        access(0, 1'b1, 11'h010, 32'hDEADBEEF, 2'b10, 1'b0, 4'b1111, 32'h0, 1'b0);
        access(0, 1'b0, 11'h010, 32'h0, 2'b10, 1'b0, 4'b0000, 32'hDEADBEEF, 1'b0);
        access(1, 1'b1, 11'h013, 32'h00000080, 2'b00, 1'b0, 4'b1000, 32'h0, 1'b0);
        access(1, 1'b0, 11'h013, 32'h0, 2'b00, 1'b0, 4'b0000, 32'hFFFFFF80, 1'b0);
        access(1, 1'b0, 11'h013, 32'h0, 2'b00, 1'b1, 4'b0000, 32'h00000080, 1'b0);
        access(0, 1'b1, 11'h016, 32'hFFFF8001, 2'b01, 1'b0, 4'b1100, 32'h0, 1'b0);
        access(0, 1'b0, 11'h016, 32'h0, 2'b01, 1'b0, 4'b0000, 32'hFFFF8001, 1'b0);
        // Error cases: misaligned half, illegal size, out-of-range word.
        access(0, 1'b0, 11'h011, 32'h0, 2'b01, 1'b0, 4'b0000, 32'h0, 1'b1);
        access(0, 1'b1, 11'h014, 32'h12345678, 2'b11, 1'b0, 4'b0000, 32'h0, 1'b1);
        access(0, 1'b1, 11'h400, 32'h12345678, 2'b10, 1'b0, 4'b0000, 32'h0, 1'b1);

        // Both ports requesting continuously with zero-wait responses.
        we[0] = 1'b0; addr[0] = 11'h000; size[0] = 2'b10;
        we[1] = 1'b0; addr[1] = 11'h004; size[1] = 2'b10;
        req[0] = 1'b1; req[1] = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (gnt[0]) seq.push_back(0);
            if (gnt[1]) seq.push_back(1);
            @(posedge clk); #1;
        end
        req[0] = 1'b0; req[1] = 1'b0;
        check32("conflict_grants", 32'(seq.size()), 32'd6);
        for (int i = 1; i < seq.size(); i++) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            check32("rr_alternate", 32'(seq[i]), 32'(1 - seq[i-1]));
`else
            check32("fixed_prio", 32'(seq[i]), 32'd0);
`endif
        end
        @(negedge clk); @(posedge clk); #1;

        // Response stall on port 0 while port 1 waits.
        we[0] = 1'b0; addr[0] = 11'h010; size[0] = 2'b10; req[0] = 1'b1;
        wait_gnt(0, got_g);
        @(posedge clk); #1;
        req[0] = 1'b0; ready[0] = 1'b0;
        we[1] = 1'b0; addr[1] = 11'h004; size[1] = 2'b10; req[1] = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check1("stall_valid", rsp_valid[0], 1'b1);
            check32("stall_rdata", rsp_rdata[0], 32'h80ADBEEF);
            check1("stall_no_gnt1", gnt[1], 1'b0);
            @(posedge clk); #1;
        end
        ready[0] = 1'b1;
        @(negedge clk);
        check1("ready_cycle_no_gnt1", gnt[1], 1'b0);
        @(posedge clk); #1;
        @(negedge clk);
        check1("gnt1_after_ready", gnt[1], 1'b1);
        @(posedge clk); #1;
        req[1] = 1'b0;
        @(negedge clk); @(posedge clk); #1;

        // Reset while a store response is pending.
        ready[1] = 1'b0;
        we[1] = 1'b1; addr[1] = 11'h020; wdata[1] = 32'h0000005A; size[1] = 2'b00; req[1] = 1'b1;
        wait_gnt(1, got_g);
        @(posedge clk); #1;
        req[1] = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        ready[1] = 1'b1;
        @(negedge clk);
        check1("rst_resp_dropped", rsp_valid[1], 1'b0);
        @(posedge clk); #1;
        access(1, 1'b0, 11'h020, 32'h0, 2'b00, 1'b1, 4'b0000, 32'h0000005A, 1'b0);

        // Randomized two-port traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            gs[0] = gnt[0];
            gs[1] = gnt[1];
            @(posedge clk); #1;
            for (int n = 0; n < 2; n++) begin
                if (req[n] && gs[n]) begin
                    if ($urandom_range(0, 1) == 1) new_txn(n);
                    else req[n] = 1'b0;
                end else if (!req[n] && $urandom_range(0, 2) == 0) begin
                    new_txn(n);
                end
                ready[n] = ($urandom_range(0, 3) != 0);
            end
        end
        req[0] = 1'b0; req[1] = 1'b0; ready[0] = 1'b1; ready[1] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
